result_display: RTL and testbench
=================================

RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 Parameter: DATA_W, default 16; result word width, exactly four hex digits.
REQ-002 Parameter: DEPTH, default 9; result buffer entries, one 3x3 NPU result matrix.
REQ-003 Parameter: HOLD_CYCLES, default 50_000_000; auto-advance period in clocks.
REQ-004 Port: clk  in  1  single system clock; all state on rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-high reset.
REQ-006 Port: in_valid  in  1  producer offers in_data.
REQ-007 Port: in_data  in  DATA_W  result word.
REQ-008 Port: in_last  in  1  marks final word of a result set; qualified by in_valid.
REQ-009 Port: in_ready  out  1  block accepts a word this cycle.
REQ-010 Port: btn_next  in  1  raw asynchronous push-button; manual advance.
REQ-011 Port: auto_en  in  1  level; enables timed auto-advance.
REQ-012 Port: clear  in  1  synchronous; discards buffer and returns to IDLE.
REQ-013 Port: hex3..hex0  out  4 each  nibbles [15:12]..[3:0] of displayed word; each feeds one seven-segment decoder.
REQ-014 Port: idx_o  out  4  index of displayed entry; feeds a fifth decoder.
REQ-015 Port: showing  out  1  high in SHOW state.

Function
REQ-016 Three states: IDLE, LOAD, SHOW; reset state IDLE.
REQ-017 in_ready SHALL equal (state != SHOW); transfer occurs on any edge with in_valid && in_ready.
REQ-018 IDLE: first transfer writes entry 0, count=1; goes to LOAD, or to SHOW if in_last.
REQ-019 LOAD: each transfer writes entry count, count+1; goes to SHOW when in_last or when count reaches DEPTH; no write beyond DEPTH-1 ever occurs.
REQ-020 On entry to SHOW: idx=0, auto counter=0.
REQ-021 SHOW: advance = manual edge OR (auto_en && counter==HOLD_CYCLES-1); simultaneous sources produce a single advance.
REQ-022 Advance: idx <= (idx==count-1) ? 0 : idx+1; count==1 keeps idx at 0.
REQ-023 Auto counter increments each SHOW cycle with auto_en high; clears on any advance, when auto_en low, and outside SHOW.
REQ-024 btn_next SHALL pass a 2-flop synchronizer then rising-edge detector; sampled high first at edge k, idx updates at edge k+2; held button gives one advance only.
REQ-025 hex3..hex0 SHALL be registered from buffer[idx], updating one clock after idx or buffer change; 0x0000 in IDLE and LOAD.
REQ-026 idx_o equals idx register; 0 outside SHOW.
REQ-027 clear has priority over transfer and advance in every state: next state IDLE, count=0, idx=0, hex outputs 0; buffer contents need not be zeroed.
REQ-028 in_last without in_valid SHALL be ignored.

Reset
REQ-029 rst asserted: state IDLE, count 0, idx 0, auto counter 0, synchronizer flops 0, hex3..hex0 0, idx_o 0, showing 0, in_ready 1.
REQ-030 Reset mid-LOAD or mid-SHOW discards the set; no partial state survives deassertion.

Structure
REQ-031 Package npu_display_pkg SHALL hold the state enum, DATA_W and DEPTH defaults.
REQ-032 Sub-module btn_edge (2-flop synchronizer plus rising-edge pulse) SHALL be instantiated once for btn_next.
REQ-033 Buffer SHALL be a register array written only by transfers; no RAM macro required.

Verification (HOLD_CYCLES=4)
REQ-034 Send 0x1234,0xABCD,0x00F0 (last on 3rd) -> showing=1, hex3..0=1,2,3,4, idx_o=0; in_ready=0.
REQ-035 Then pulse btn_next 3 times, each held 5 cycles -> displays 0xABCD, 0x00F0, then wraps to 0x1234, idx 1,2,0; exactly one advance per press.
REQ-036 Send 9 words 0x0001..0x0009, no in_last -> SHOW after 9th, in_ready=0 thereafter; 10th offered word never accepted.
REQ-037 auto_en=1 in SHOW with count=2 -> idx toggles every 4 clocks; btn edge coinciding with terminal count -> single advance, counter restarts.
REQ-038 clear asserted same cycle as transfer in LOAD -> word dropped, IDLE, hex=0x0000, in_ready=1.
REQ-039 rst asserted mid-SHOW -> all outputs to REQ-029 values immediately, asynchronously; single word with in_last after release -> SHOW, count=1, button presses keep idx 0.

Source files
------------

// File: rtl/npu_display_pkg.sv
// Shared types and defaults for the NPU result display block.
package npu_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SHOW = 2'd2
    } state_e;

    localparam int DATA_W_DEF      = 16;
    localparam int DEPTH_DEF       = 9;
    localparam int HOLD_CYCLES_DEF = 50_000_000;

    // Width of the entry count and display index; covers buffers up to 16 entries.
    localparam int CNT_W = 5;

    // Next display index, wrapping to entry 0 after the last valid entry.
    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] idx,
                                                  input logic [CNT_W-1:0] count);
        if (idx == count - CNT_W'(1)) begin
            return '0;
        end
        return idx + CNT_W'(1);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer for a raw push-button followed by a rising-edge pulse.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/result_display.sv
// Captures a set of NPU result words and steps through them on hex displays,
// advanced manually by a push-button or automatically by a hold timer.
module result_display
    import npu_display_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              btn_next,
    input  logic              auto_en,
    input  logic              clear,
    output logic [3:0]        hex3,
    output logic [3:0]        hex2,
    output logic [3:0]        hex1,
    output logic [3:0]        hex0,
    output logic [3:0]        idx_o,
    output logic              showing
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [HOLD_W-1:0]   auto_q, auto_d;
    logic [DATA_W-1:0]   hex_q, hex_d;
    logic [DATA_W-1:0]   buf_q [DEPTH];
    logic [DATA_W-1:0]   rd_word;
    logic [CNT_W-1:0]    wr_ptr;
    logic                wr_en;
    logic                transfer;
    logic                advance;
    logic                btn_pulse;

    btn_edge u_btn_edge (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_next),
        .pulse_o (btn_pulse)
    );

    assign transfer = in_valid && (state_q != ST_SHOW);
    assign advance  = btn_pulse || (auto_en && (auto_q == HOLD_LAST));

    // Select the buffer entry addressed by the current display index.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx_q == CNT_W'(i)) begin
                rd_word = buf_q[i];
            end
        end
    end

    // Next-state logic; clear overrides transfers and advances in every state.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        auto_d  = '0;
        hex_d   = '0;
        wr_en   = 1'b0;
        wr_ptr  = count_q;

        if (clear) begin
            state_d = ST_IDLE;
            count_d = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (transfer) begin
                        wr_en   = 1'b1;
                        wr_ptr  = '0;
                        count_d = CNT_W'(1);
                        idx_d   = '0;
                        state_d = (in_last || DEPTH == 1) ? ST_SHOW : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (transfer) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CNT_W'(1);
                        if (in_last || count_q == LAST_SLOT) begin
                            state_d = ST_SHOW;
                            idx_d   = '0;
                        end
                    end
                end
                ST_SHOW: begin
                    hex_d = rd_word;
                    if (advance) begin
                        idx_d = wrap_inc(idx_q, count_q);
                    end else if (auto_en) begin
                        auto_d = auto_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Control and display registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            auto_q  <= '0;
            hex_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            auto_q  <= auto_d;
            hex_q   <= hex_d;
        end
    end

    // Result buffer; only accepted transfers write it, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && wr_ptr == CNT_W'(i)) begin
                buf_q[i] <= in_data;
            end
        end
    end

    assign in_ready = (state_q != ST_SHOW);
    assign showing  = (state_q == ST_SHOW);
    assign idx_o    = showing ? idx_q[3:0] : 4'd0;
    assign hex3     = hex_q[15:12];
    assign hex2     = hex_q[11:8];
    assign hex1     = hex_q[7:4];
    assign hex0     = hex_q[3:0];

endmodule

// File: tb/tb_result_display.sv
// Scoreboard bench for result_display with a short hold period.
module tb_result_display;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        btn_next;
    logic        auto_en;
    logic        clear;
    logic [3:0]  hex3, hex2, hex1, hex0, idx_o;
    logic        showing;
    logic [15:0] word;

    result_display #(.DATA_W(16), .DEPTH(9), .HOLD_CYCLES(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .btn_next (btn_next),
        .auto_en  (auto_en),
        .clear    (clear),
        .hex3     (hex3),
        .hex2     (hex2),
        .hex1     (hex1),
        .hex0     (hex0),
        .idx_o    (idx_o),
        .showing  (showing)
    );

    always #5 clk = ~clk;
    assign word = {hex3, hex2, hex1, hex0};

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] word;
    } ev_t;

    ev_t         exp_q[$];
    int          ev_cyc[$];
    logic [15:0] model_buf[$];
    int          model_cnt = 0;
    int          model_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: a display event is SHOW entry or an index change; the word is
    // compared one cycle later, once the registered hex outputs have followed.
    logic       prev_show = 1'b0;
    logic [3:0] prev_idx  = 4'd0;
    bit         pending   = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if (pending) begin
            pending = 1'b0;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_event: idx %0d word %04h, none expected", idx_o, word);
            end else begin
                e = exp_q.pop_front();
                check("disp_idx", 32'(idx_o), 32'(e.idx));
                check("disp_word", 32'(word), 32'(e.word));
            end
        end
        if (showing && (!prev_show || idx_o != prev_idx)) begin
            pending = 1'b1;
            ev_cyc.push_back(cyc);
        end
        prev_show = showing;
        prev_idx  = idx_o;
    end

    task automatic push_ev(input int idx);
        ev_t e;
        e.idx  = 4'(idx);
        e.word = model_buf[idx];
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [15:0] d, input bit last, output bit acc);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        acc      = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends a complete set (ends on last word or at 9 words) and models the SHOW entry.
    task automatic load_set(input logic [15:0] w[$], input bit last_on_final, input int gap_max);
        bit acc;
        model_buf = w;
        model_cnt = w.size();
        model_idx = 0;
        for (int i = 0; i < w.size(); i++) begin
            if (i == w.size() - 1) push_ev(0);
            send(w[i], (i == w.size() - 1) && last_on_final, acc);
            check("accept", 32'(acc), 32'd1);
            for (int g = 0; g < int'($urandom_range(gap_max, 0)); g++) begin
                in_last = 1'($urandom_range(1, 0));
                @(negedge clk);
            end
            in_last = 1'b0;
        end
    endtask

    task automatic press(input int hold);
        int c0;
        @(negedge clk);
        btn_next = 1'b1;
        c0 = cyc;
        if (model_cnt > 1) begin
            model_idx = (model_idx + 1) % model_cnt;
            push_ev(model_idx);
        end
        repeat (hold) @(negedge clk);
        btn_next = 1'b0;
        repeat (4) @(negedge clk);
        if (model_cnt > 1) check("btn_latency", 32'(ev_cyc[$]), 32'(c0 + 3));
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_showing"}, 32'(showing), 32'd0);
        check({tag, "_idx"}, 32'(idx_o), 32'd0);
        check({tag, "_hex"}, 32'(word), 32'd0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_cnt = 0;
        check_idle("clear");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w[$];
        bit acc;
        int n0, c0, len;
        bit lst;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        btn_next = 1'b0; auto_en = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Three-word set, last on third.
        w = '{16'h1234, 16'hABCD, 16'h00F0};
        load_set(w, 1'b1, 0);
        @(negedge clk);
        check("set3_showing", 32'(showing), 32'd1);
        check("set3_in_ready", 32'(in_ready), 32'd0);
        check("set3_hex", 32'({hex3, hex2, hex1, hex0}), 32'h1234);
        drain();
        for (int i = 0; i < 3; i++) press(5);
        drain();
        do_clear();

        // Nine words with no last: buffer full, tenth word refused.
        w = {};
        for (int i = 1; i <= 9; i++) w.push_back(16'(i));
        load_set(w, 1'b0, 0);
        send(16'h000A, 1'b1, acc);
        check("tenth_refused", 32'(acc), 32'd0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        drain();
        press(3);
        drain();
        do_clear();

        // Auto-advance with two entries toggles every HOLD clocks.
        w = '{16'h5A5A, 16'hC3C3};
        load_set(w, 1'b1, 0);
        drain();
        n0 = ev_cyc.size();
        for (int i = 0; i < 4; i++) push_ev((i + 1) % 2);
        @(negedge clk);
        auto_en = 1'b1;
        c0 = cyc;
        repeat (4 * HOLD + 1) @(negedge clk);
        auto_en = 1'b0;
        drain();
        check("auto_events", 32'(ev_cyc.size() - n0), 32'd4);
        for (int i = 0; i < 4 && n0 + i < ev_cyc.size(); i++)
            check("auto_period", 32'(ev_cyc[n0 + i]), 32'(c0 + HOLD * (i + 1)));
        do_clear();

        // Button edge landing on the terminal count gives one advance.
        w = '{16'h1111, 16'h2222, 16'h3333};
        load_set(w, 1'b1, 0);
        drain();
        n0 = ev_cyc.size();
        push_ev(1);
        push_ev(2);
        @(negedge clk);
        auto_en = 1'b1;
        c0 = cyc;
        @(negedge clk);
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        btn_next = 1'b0;
        repeat (5) @(negedge clk);
        auto_en = 1'b0;
        drain();
        check("coincide_events", 32'(ev_cyc.size() - n0), 32'd2);
        if (ev_cyc.size() - n0 == 2) begin
            check("coincide_first", 32'(ev_cyc[n0]), 32'(c0 + HOLD));
            check("coincide_restart", 32'(ev_cyc[n0 + 1]), 32'(c0 + 2 * HOLD));
        end
        do_clear();

        // Clear in the same cycle as a LOAD transfer drops the word.
        send(16'h7777, 1'b0, acc);
        check("load_accept", 32'(acc), 32'd1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h8888;
        clear    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        check_idle("clear_xfer");
        model_cnt = 0;

        // Asynchronous reset mid-SHOW, then a single-entry set.
        w = '{16'h4321, 16'h9876};
        load_set(w, 1'b1, 0);
        press(4);
        drain();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_idle("async_rst");
        @(negedge clk);
        rst = 1'b0;
        w = '{16'hBEEF};
        load_set(w, 1'b1, 0);
        drain();
        press(3);
        press(6);
        check("single_idx", 32'(idx_o), 32'd0);
        drain();
        do_clear();

        // Randomized sets and presses.
        for (int it = 0; it < 15; it++) begin
            len = $urandom_range(9, 1);
            w = {};
            for (int i = 0; i < len; i++) w.push_back(16'($urandom));
            lst = (len < 9) ? 1'b1 : 1'($urandom_range(1, 0));
            load_set(w, lst, 2);
            drain();
            for (int p = 0; p < int'($urandom_range(4, 0)); p++) press($urandom_range(6, 3));
            drain();
            do_clear();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
